// File: rtl/pim_indirect_arg_bank.sv
// Captures host writes of indirect args and per-bank LUT-X words, with load FSM.
// Define PIM_INDIRECT_BYTE_STRB_EN to add the i_write_strb byte-strobe port.
module pim_indirect_arg_bank #(
   parameter int DATA_WIDTH = 256,
   parameter int ADDR_WIDTH = 32,
   parameter int ARG_WIDTH = 32,
   parameter int NUM_ARGS = 3,
   parameter logic [ADDR_WIDTH-1:0] ARGS_BASE = 'h0000_1000,
   parameter logic [ADDR_WIDTH-1:0] ARGS_STRIDE = 'h0000_1000,
   parameter int BANK_BITS = 4,
   parameter int BANK_LSB = 5,
   parameter logic [ADDR_WIDTH-1:0] LUT_BASE = 'h0000_8000,
   parameter int LUT_SPAN_LOG2 = 9
) (
   input  logic clk,
   input  logic rst,
   input  logic i_write_en,
   input  logic [ADDR_WIDTH-1:0] i_addr,
   input  logic [DATA_WIDTH-1:0] i_write_data,
`ifdef PIM_INDIRECT_BYTE_STRB_EN
   input  logic [DATA_WIDTH/8-1:0] i_write_strb,
`endif
   input  logic i_PIM_dev_working,
   input  logic i_HPC_clear,
   input  logic i_lock,
   output logic [NUM_ARGS*ARG_WIDTH-1:0] o_args,
   output logic [NUM_ARGS-1:0] o_arg_valid,
   output logic [(2**BANK_BITS)*DATA_WIDTH-1:0] o_lut_x,
   output logic [(2**BANK_BITS)-1:0] o_bank_valid,
   output logic [1:0] o_state,
   output logic o_ready,
   output logic o_drop_err,
   output logic [7:0] o_reject_cnt
);

   localparam int NB = 2**BANK_BITS;
   localparam int SB = DATA_WIDTH/8;
   localparam int AB = ARG_WIDTH/8;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      LOADING = 2'd1,
      READY   = 2'd2
   } state_t;

   logic [SB-1:0] strb;
`ifdef PIM_INDIRECT_BYTE_STRB_EN
   assign strb = i_write_strb;
`else
   assign strb = '1;
`endif

   logic [NUM_ARGS-1:0] arg_hit;
   logic lut_hit;

   always_comb begin
      arg_hit = '0;
      for (int k = 0; k < NUM_ARGS; k++)
         if (i_addr == ARGS_BASE + ADDR_WIDTH'(k) * ARGS_STRIDE)
            arg_hit[k] = 1'b1;
      // partial-width arg writes are not hits at all
      if (!(&strb[AB-1:0]))
         arg_hit = '0;
   end

   assign lut_hit = i_addr[ADDR_WIDTH-1:LUT_SPAN_LOG2]
                 == LUT_BASE[ADDR_WIDTH-1:LUT_SPAN_LOG2];

   logic [NUM_ARGS-1:0] c_arg;
   logic c_lut;
   logic c_dev;
   logic [BANK_BITS-1:0] c_bank;
   logic [DATA_WIDTH-1:0] c_data;
   logic [SB-1:0] c_strb;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         c_arg  <= '0;
         c_lut  <= 1'b0;
         c_dev  <= 1'b0;
         c_bank <= '0;
         c_data <= '0;
         c_strb <= '0;
      end else if (i_HPC_clear) begin
         c_arg  <= '0;
         c_lut  <= 1'b0;
         c_dev  <= 1'b0;
         c_bank <= '0;
         c_data <= '0;
         c_strb <= '0;
      end else begin
         c_arg  <= i_write_en ? arg_hit : '0;
         c_lut  <= i_write_en & lut_hit;
         c_dev  <= i_PIM_dev_working;
         c_bank <= i_addr[BANK_LSB +: BANK_BITS];
         c_data <= i_write_data;
         c_strb <= strb;
      end
   end

   logic [ARG_WIDTH-1:0] arg_mem [NUM_ARGS];
   logic [DATA_WIDTH-1:0] lut_mem [NB];
   logic [NUM_ARGS-1:0] arg_valid;
   logic [NB-1:0] bank_valid;
   state_t state;
   logic drop_err;
   logic [7:0] rej_cnt;

   logic lut_ok, drop, rej, lut_wr, commit;
   logic [NUM_ARGS-1:0] arg_wr, av_nxt;
   logic [NB-1:0] bv_nxt;
   logic [DATA_WIDTH-1:0] merged;

   always_comb begin
      lut_ok = c_lut & c_dev;
      drop   = c_lut & ~c_dev;
      rej    = ((|c_arg) | lut_ok) & i_lock;
      arg_wr = i_lock ? '0 : c_arg;
      lut_wr = lut_ok & ~i_lock & (|c_strb);
      commit = (|arg_wr) | lut_wr;
      av_nxt = arg_valid | arg_wr;
      bv_nxt = bank_valid;
      if (lut_wr)
         bv_nxt[c_bank] = 1'b1;
      merged = lut_mem[c_bank];
      for (int i = 0; i < SB; i++)
         if (c_strb[i])
            merged[i*8 +: 8] = c_data[i*8 +: 8];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < NUM_ARGS; k++) arg_mem[k] <= '0;
         for (int b = 0; b < NB; b++) lut_mem[b] <= '0;
         arg_valid  <= '0;
         bank_valid <= '0;
         state      <= IDLE;
         drop_err   <= 1'b0;
         rej_cnt    <= '0;
      end else if (i_HPC_clear) begin
         for (int k = 0; k < NUM_ARGS; k++) arg_mem[k] <= '0;
         for (int b = 0; b < NB; b++) lut_mem[b] <= '0;
         arg_valid  <= '0;
         bank_valid <= '0;
         state      <= IDLE;
         drop_err   <= 1'b0;
         rej_cnt    <= '0;
      end else begin
         for (int k = 0; k < NUM_ARGS; k++)
            if (arg_wr[k]) arg_mem[k] <= c_data[ARG_WIDTH-1:0];
         if (lut_wr)
            lut_mem[c_bank] <= merged;
         arg_valid  <= av_nxt;
         bank_valid <= bv_nxt;
         if (drop)
            drop_err <= 1'b1;
         if (rej && rej_cnt != 8'hFF)
            rej_cnt <= rej_cnt + 8'd1;
         if (commit)
            state <= (&av_nxt && &bv_nxt) ? READY : LOADING;
      end
   end

   always_comb begin
      o_args = '0;
      for (int k = 0; k < NUM_ARGS; k++)
         o_args[k*ARG_WIDTH +: ARG_WIDTH] = arg_mem[k];
      o_lut_x = '0;
      for (int b = 0; b < NB; b++)
         o_lut_x[b*DATA_WIDTH +: DATA_WIDTH] = lut_mem[b];
   end

   assign o_arg_valid  = arg_valid;
   assign o_bank_valid = bank_valid;
   assign o_state      = state;
   assign o_ready      = (state == READY);
   assign o_drop_err   = drop_err;
   assign o_reject_cnt = rej_cnt;

endmodule

// File: tb/tb_pim_indirect_arg_bank.sv
// Scoreboard bench for pim_indirect_arg_bank (default build, no strobes).
// Transaction-level model predicts every output after each clock edge.
module tb_pim_indirect_arg_bank;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic we = 1'b0, dev = 1'b0, clr = 1'b0, lock = 1'b0;
   logic [31:0] addr = '0;
   logic [255:0] wdata = '0;

   logic [95:0] args;
   logic [2:0] av;
   logic [4095:0] lut;
   logic [15:0] bv;
   logic [1:0] st;
   logic rdy, derr;
   logic [7:0] rcnt;

   pim_indirect_arg_bank dut (
      .clk(clk), .rst(rst),
      .i_write_en(we), .i_addr(addr), .i_write_data(wdata),
      .i_PIM_dev_working(dev), .i_HPC_clear(clr), .i_lock(lock),
      .o_args(args), .o_arg_valid(av), .o_lut_x(lut),
      .o_bank_valid(bv), .o_state(st), .o_ready(rdy),
      .o_drop_err(derr), .o_reject_cnt(rcnt)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [95:0] args;
      logic [2:0] av;
      logic [4095:0] lut;
      logic [15:0] bv;
      logic [1:0] st;
      logic drop;
      logic [7:0] rej;
   } exp_t;

   exp_t exp_q[$];
   int total = 0;
   int bad = 0;

   logic [31:0] m_args [3];
   logic [255:0] m_lut [16];
   logic [2:0] m_av;
   logic [15:0] m_bv;
   int m_st, m_rej;
   bit m_drop;
   bit p_v, p_dev;
   logic [31:0] p_addr;
   logic [255:0] p_data;

   task automatic chk(input string n, input logic [255:0] a, input logic [255:0] x);
      total++;
      if (a !== x) begin
         bad++;
         $display("FAIL %s act=%h exp=%h", n, a, x);
      end
   endtask

   function automatic int arg_idx(input logic [31:0] a);
      int i;
      if (a < 32'h1000 || (a % 32'h1000) != 0) return -1;
      i = int'(a / 32'h1000) - 1;
      return (i < 3) ? i : -1;
   endfunction

   function automatic bit is_lut(input logic [31:0] a);
      return a >= 32'h8000 && a < 32'h8200;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 3; k++) m_args[k] = '0;
      for (int b = 0; b < 16; b++) m_lut[b] = '0;
      m_av = '0; m_bv = '0; m_st = 0; m_rej = 0; m_drop = 0;
      p_v = 0; p_dev = 0; p_addr = '0; p_data = '0;
   endtask

   task automatic model_step();
      int k, b;
      if (rst || clr) begin
         model_reset();
         return;
      end
      if (p_v) begin
         k = arg_idx(p_addr);
         b = int'((p_addr - 32'h8000) / 32);
         if (is_lut(p_addr) && !p_dev)
            m_drop = 1;
         else if (k >= 0 || is_lut(p_addr)) begin
            if (lock) begin
               if (m_rej < 255) m_rej++;
            end else begin
               if (k >= 0) begin
                  m_args[k] = p_data[31:0];
                  m_av[k] = 1'b1;
               end else begin
                  m_lut[b] = p_data;
                  m_bv[b] = 1'b1;
               end
               m_st = (m_av == 3'b111 && m_bv == 16'hFFFF) ? 2 : 1;
            end
         end
      end
      p_v = we; p_addr = addr; p_data = wdata; p_dev = dev;
   endtask

   function automatic exp_t snap();
      exp_t e;
      for (int k = 0; k < 3; k++) e.args[k*32 +: 32] = m_args[k];
      for (int b = 0; b < 16; b++) e.lut[b*256 +: 256] = m_lut[b];
      e.av = m_av; e.bv = m_bv; e.st = 2'(m_st);
      e.drop = m_drop; e.rej = 8'(m_rej);
      return e;
   endfunction

   task automatic cyc(input bit w, input logic [31:0] a, input logic [255:0] d,
                      input bit dv, input bit lk, input bit cl);
      @(negedge clk);
      we = w; addr = a; wdata = d; dev = dv; lock = lk; clr = cl;
      @(posedge clk);
      model_step();
      exp_q.push_back(snap());
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, 32'h0, '0, 1, 0, 0);
   endtask

   function automatic logic [255:0] rdata();
      logic [255:0] d;
      for (int i = 0; i < 8; i++) d[i*32 +: 32] = $urandom;
      return d;
   endfunction

   function automatic logic [31:0] raddr();
      logic [31:0] miss [5];
      miss[0] = 32'h4000; miss[1] = 32'h1004; miss[2] = 32'h8200;
      miss[3] = 32'h7FFF; miss[4] = 32'h0;
      case ($urandom % 5)
         0: return 32'h1000 * $urandom_range(1, 3);
         1: return 32'h8000 + ($urandom % 512);
         2: return 32'h8000 + 32 * $urandom_range(0, 15);
         3: return $urandom;
         default: return miss[$urandom % 5];
      endcase
   endfunction

   task automatic chk_zero(input string n);
      chk({n, "_args"}, 256'(args), '0);
      chk({n, "_av"}, 256'(av), '0);
      chk({n, "_bv"}, 256'(bv), '0);
      chk({n, "_st"}, 256'(st), '0);
      chk({n, "_rdy"}, 256'(rdy), '0);
      chk({n, "_drop"}, 256'(derr), '0);
      chk({n, "_rej"}, 256'(rcnt), '0);
      chk({n, "_lut"}, 256'(|lut), '0);
   endtask

   always @(posedge clk) begin
      exp_t e;
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("args", 256'(args), 256'(e.args));
         chk("arg_valid", 256'(av), 256'(e.av));
         chk("bank_valid", 256'(bv), 256'(e.bv));
         chk("state", 256'(st), 256'(e.st));
         chk("ready", 256'(rdy), 256'(e.st == 2'd2));
         chk("drop_err", 256'(derr), 256'(e.drop));
         chk("reject_cnt", 256'(rcnt), 256'(e.rej));
         for (int b = 0; b < 16; b++)
            chk($sformatf("lut%0d", b), lut[b*256 +: 256], e.lut[b*256 +: 256]);
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      model_reset();
      #1 rst = 1'b1;
      #1 chk_zero("reset");
      idle(2);
      @(negedge clk) rst = 1'b0;

      cyc(1, 32'h1000, 256'h1234_5678, 1, 0, 0);
      idle(1);
      #1;
      chk("t1_arg0", 256'(args[31:0]), 256'h1234_5678);
      chk("t1_av", 256'(av), 256'b001);
      chk("t1_state", 256'(st), 256'd1);

      cyc(1, 32'h2000, rdata(), 1, 0, 0);
      cyc(1, 32'h3000, rdata(), 1, 0, 0);
      for (int b = 0; b < 16; b++)
         cyc(1, 32'h8000 + 32 * b, 256'(b), 1, 0, 0);
      idle(1);
      #1 chk("t2_ready", 256'(rdy), 256'd1);

      cyc(1, 32'h81E0, rdata(), 0, 0, 0);
      idle(2);
      #1;
      chk("t3_bank15", lut[15*256 +: 256], 256'd15);
      chk("t3_drop", 256'(derr), 256'd1);

      for (int i = 0; i < 300; i++) begin
         if (i % 2 == 0) cyc(1, 32'h1000 * $urandom_range(1, 3), rdata(), 1, 1, 0);
         else cyc(1, 32'h8000 + 32 * $urandom_range(0, 15), rdata(), 1, 1, 0);
      end
      cyc(0, 32'h0, '0, 1, 1, 0);
      idle(1);
      #1;
      chk("t4_rej", 256'(rcnt), 256'd255);
      chk("t4_state", 256'(st), 256'd2);

      cyc(1, 32'h1000, rdata(), 1, 0, 0);
      cyc(0, 32'h0, '0, 1, 0, 1);
      idle(1);
      #1;
      chk("t5_state", 256'(st), 256'd0);
      chk("t5_av", 256'(av), 256'd0);

      for (int b = 0; b < 7; b++)
         cyc(1, 32'h8000 + 32 * b, rdata(), 1, 0, 0);
      idle(1);
      #2 rst = 1'b1;
      #1 chk_zero("t6_async");
      model_reset();
      idle(2);
      @(negedge clk) rst = 1'b0;
      cyc(1, 32'h2000, rdata(), 1, 0, 0);
      idle(2);
      #1 chk("t6_state", 256'(st), 256'd1);

      for (int i = 0; i < 3000; i++)
         cyc(($urandom % 4) != 0, raddr(), rdata(), ($urandom % 8) != 0,
             ($urandom % 8) == 0, ($urandom % 64) == 0);
      idle(3);
      @(negedge clk);
      chk("queue_drained", 256'(exp_q.size()), '0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
